spi_pixel_loader: RTL and testbench

Upstream input stage of the Floyd-Steinberg dithering accelerator. It receives 8-bit grayscale pixels from the MCU over SPI (mode 0, MSB first) and writes them sequentially into the image SRAM at addresses 0 to IMAGE_SIZE-1. When the frame is complete it raises `data_valid`, which releases the dithering state machine to start its pass.

---
 rtl/spi_pixel_loader_pkg.sv | 21 ++
 rtl/spi_edge_sync.sv | 36 +++
 rtl/spi_pixel_loader.sv | 138 +++++++++++++
 tb/tb_spi_pixel_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pixel_loader_pkg.sv
// State encodings shared by the dithering accelerator blocks.
package states;

    // Dithering pass sequencer states.
    typedef enum logic [2:0] {
        DI_IDLE,
        DI_READ,
        DI_ERR,
        DI_WRITE,
        DI_DONE
    } dither_state_t;

    // SPI pixel loader states.
    typedef enum logic [1:0] {
        LD_IDLE,
        LD_SHIFT,
        LD_WRITE,
        LD_DONE
    } loader_state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Brings the asynchronous SPI pins into the system clock domain and
// produces a one-cycle pulse for each rising SPI_CLK edge.
module spi_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_clk,
    input  logic spi_cs,
    input  logic spi_mosi,
    output logic clk_rise,
    output logic cs_s,
    output logic mosi_s
);

    logic [2:0] clk_q;
    logic [1:0] cs_q;
    logic [1:0] mosi_q;

    // Two-stage synchronizers; SPI_CLK gets a third stage for edge detect.
    // CS resets to deselected so no phantom transfer is seen after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_q  <= '0;
            cs_q   <= 2'b11;
            mosi_q <= '0;
        end else begin
            clk_q  <= {clk_q[1:0], spi_clk};
            cs_q   <= {cs_q[0], spi_cs};
            mosi_q <= {mosi_q[0], spi_mosi};
        end
    end

    assign clk_rise = clk_q[1] & ~clk_q[2];
    assign cs_s     = cs_q[1];
    assign mosi_s   = mosi_q[1];

endmodule

// File: rtl/spi_pixel_loader.sv
// SPI (mode 0, MSB first) pixel receiver that fills the image SRAM from
// address 0 and flags the frame valid once the last pixel lands.
// Optional feature: define LOADER_CHECKSUM_EN to keep a mod-256 byte sum.
module spi_pixel_loader
    import states::*;
#(
    parameter int IMAGEX           = 16,
    parameter int IMAGEY           = 16,
    parameter int IMAGE_SIZE       = IMAGEX * IMAGEY,
    parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
    parameter int RGB_SIZE         = 8
) (
    input  logic                        MAX10_CLK1_50,
    input  logic                        reset_n,
    input  logic                        SPI_CLK,
    input  logic                        SPI_CS,
    input  logic                        SPI_MOSI,
    input  logic                        MCU_TX_RDY,
    output logic                        MCU_RX_RDY,
    output logic                        sram_we,
    output logic [IMAGE_ADDR_WIDTH-1:0] sram_addr,
    output logic [RGB_SIZE-1:0]         sram_wdata,
    output logic                        load_done,
    output logic                        data_valid,
    output logic [7:0]                  load_checksum
);

    localparam int BCW = $clog2(RGB_SIZE);

    logic                        clk_rise, cs_s, mosi_s;
    loader_state_t               state_q, state_d;
    logic [IMAGE_ADDR_WIDTH-1:0] addr_q;
    logic [BCW-1:0]              bit_cnt_q;
    logic [RGB_SIZE-1:0]         shreg_q;
    logic                        last_bit, last_addr, bit_take;

    spi_edge_sync u_sync (
        .clk      (MAX10_CLK1_50),
        .rst_n    (reset_n),
        .spi_clk  (SPI_CLK),
        .spi_cs   (SPI_CS),
        .spi_mosi (SPI_MOSI),
        .clk_rise (clk_rise),
        .cs_s     (cs_s),
        .mosi_s   (mosi_s)
    );

    assign last_bit  = bit_cnt_q == BCW'(RGB_SIZE - 1);
    assign last_addr = addr_q == IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);
    // A deselected bus never shifts, even if SPI_CLK toggles.
    assign bit_take  = clk_rise & ~cs_s;

    // State register.
    always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
        if (!reset_n) state_q <= LD_IDLE;
        else          state_q <= state_d;
    end

    // Next-state decode and ready flag.
    always_comb begin
        state_d    = state_q;
        MCU_RX_RDY = 1'b0;
        case (state_q)
            LD_IDLE: begin
                MCU_RX_RDY = 1'b1;
                if (MCU_TX_RDY) state_d = LD_SHIFT;
            end
            LD_SHIFT: if (bit_take && last_bit) state_d = LD_WRITE;
            LD_WRITE: state_d = last_addr ? LD_DONE : LD_SHIFT;
            LD_DONE:  state_d = LD_IDLE;
            default:  state_d = LD_IDLE;
        endcase
    end

    // Datapath: bit assembly, address walk and registered SRAM/status outputs.
    always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            load_done  <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            sram_we   <= 1'b0;
            load_done <= 1'b0;
            case (state_q)
                LD_IDLE: begin
                    if (MCU_TX_RDY) begin
                        addr_q     <= '0;
                        bit_cnt_q  <= '0;
                        data_valid <= 1'b0;
                    end
                end
                LD_SHIFT: begin
                    // CS high drops any partial byte; the next byte's eight
                    // shifts flush the stale bits out of shreg.
                    if (cs_s) begin
                        bit_cnt_q <= '0;
                    end else if (clk_rise) begin
                        shreg_q   <= {shreg_q[RGB_SIZE-2:0], mosi_s};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                LD_WRITE: begin
                    sram_we    <= 1'b1;
                    sram_addr  <= addr_q;
                    sram_wdata <= shreg_q;
                    bit_cnt_q  <= '0;
                    if (!last_addr) addr_q <= addr_q + 1'b1;
                end
                LD_DONE: begin
                    load_done  <= 1'b1;
                    data_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_q;

    // Running mod-256 sum of the bytes written since the last frame start.
    always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
        if (!reset_n)                              csum_q <= '0;
        else if (state_q == LD_IDLE && MCU_TX_RDY) csum_q <= '0;
        else if (state_q == LD_WRITE)              csum_q <= csum_q + 8'(shreg_q);
    end

    assign load_checksum = csum_q;
`else
    assign load_checksum = 8'h00;
`endif

endmodule

// File: tb/tb_spi_pixel_loader.sv
// Directed bench for spi_pixel_loader: reset values, byte assembly and
// write latency, CS abort, full frame, ignored mid-frame start, reset abort.
module tb_spi_pixel_loader;

    logic       MAX10_CLK1_50 = 1'b0;
    logic       reset_n       = 1'b0;
    logic       SPI_CLK       = 1'b0;
    logic       SPI_CS        = 1'b1;
    logic       SPI_MOSI      = 1'b0;
    logic       MCU_TX_RDY    = 1'b0;
    logic       MCU_RX_RDY;
    logic       sram_we;
    logic [7:0] sram_addr;
    logic [7:0] sram_wdata;
    logic       load_done;
    logic       data_valid;
    logic [7:0] load_checksum;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] wr_addr[$];
    logic [7:0] wr_data[$];
    int         done_cnt = 0;

    spi_pixel_loader dut (
        .MAX10_CLK1_50 (MAX10_CLK1_50),
        .reset_n       (reset_n),
        .SPI_CLK       (SPI_CLK),
        .SPI_CS        (SPI_CS),
        .SPI_MOSI      (SPI_MOSI),
        .MCU_TX_RDY    (MCU_TX_RDY),
        .MCU_RX_RDY    (MCU_RX_RDY),
        .sram_we       (sram_we),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .load_done     (load_done),
        .data_valid    (data_valid),
        .load_checksum (load_checksum)
    );

    always #5 MAX10_CLK1_50 = ~MAX10_CLK1_50;

    // Record every SRAM write and done pulse, sampled mid-cycle.
    always @(negedge MAX10_CLK1_50) begin
        if (sram_we) begin
            wr_addr.push_back(sram_addr);
            wr_data.push_back(sram_wdata);
        end
        if (load_done) done_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge MAX10_CLK1_50);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        SPI_CLK    = 1'b0;
        SPI_CS     = 1'b1;
        SPI_MOSI   = 1'b0;
        MCU_TX_RDY = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
    endtask

    task automatic start_frame();
        MCU_TX_RDY = 1'b1;
        cyc(1);
        MCU_TX_RDY = 1'b0;
        SPI_CS     = 1'b0;
        cyc(3);
    endtask

    // One SPI bit at clk/8: 4 cycles low with data set up, 4 cycles high.
    task automatic send_bit(input logic b);
        SPI_MOSI = b;
        cyc(4);
        SPI_CLK = 1'b1;
        cyc(4);
        SPI_CLK = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        SPI_CS     = 1'b1;
        MCU_TX_RDY = 1'b0;
        cyc(2);
        n_cmp++; if (MCU_RX_RDY !== 1'b1) begin n_bad++; $display("FAIL reset_rx_rdy got %b want 1", MCU_RX_RDY); end
        n_cmp++; if (sram_we !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b want 0", sram_we); end
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", data_valid); end
        n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", load_done); end
        n_cmp++; if (load_checksum !== 8'h00) begin n_bad++; $display("FAIL reset_csum got %h want 00", load_checksum); end
        n_cmp++; if (sram_addr !== 8'h00) begin n_bad++; $display("FAIL reset_addr got %h want 00", sram_addr); end
        reset_n = 1'b1;
        cyc(1);
    endtask

    // 8'hA5 MSB first; sram_we must appear exactly 4 cycles after the 8th rise.
    task automatic test_byte_latency();
        logic [7:0] b;
        int base;
        b = 8'hA5;
        do_reset();
        start_frame();
        base = wr_addr.size();
        n_cmp++; if (MCU_RX_RDY !== 1'b0) begin n_bad++; $display("FAIL busy_rx_rdy got %b want 0", MCU_RX_RDY); end
        for (int i = 7; i >= 1; i--) send_bit(b[i]);
        SPI_MOSI = b[0];
        cyc(4);
        SPI_CLK = 1'b1;
        cyc(3);
        n_cmp++; if (sram_we !== 1'b0) begin n_bad++; $display("FAIL a5_early_we got %b want 0 at 3 cycles", sram_we); end
        cyc(1);
        n_cmp++; if (sram_we !== 1'b1) begin n_bad++; $display("FAIL a5_we_latency got %b want 1 at 4 cycles", sram_we); end
        n_cmp++; if (sram_wdata !== 8'hA5) begin n_bad++; $display("FAIL a5_wdata got %h want a5", sram_wdata); end
        n_cmp++; if (sram_addr !== 8'h00) begin n_bad++; $display("FAIL a5_addr got %h want 00", sram_addr); end
        SPI_CLK = 1'b0;
        cyc(4);
        n_cmp++; if (wr_addr.size() - base !== 1) begin n_bad++; $display("FAIL a5_write_count got %0d want 1", wr_addr.size() - base); end
    endtask

    // CS dropped after 5 bits: partial byte discarded, next full byte lands at 0.
    task automatic test_cs_abort();
        int base;
        do_reset();
        start_frame();
        base = wr_addr.size();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        SPI_CS = 1'b1;
        cyc(8);
        SPI_CS = 1'b0;
        cyc(4);
        send_byte(8'h3C);
        cyc(4);
        n_cmp++; if (wr_addr.size() - base !== 1) begin n_bad++; $display("FAIL cs_abort_count got %0d want 1", wr_addr.size() - base); end
        if (wr_addr.size() > base) begin
            n_cmp++; if (wr_addr[base] !== 8'h00) begin n_bad++; $display("FAIL cs_abort_addr got %h want 00", wr_addr[base]); end
            n_cmp++; if (wr_data[base] !== 8'h3C) begin n_bad++; $display("FAIL cs_abort_data got %h want 3c", wr_data[base]); end
        end
    endtask

    // Full 256-byte frame of 8'hFF.
    task automatic test_full_frame();
        int base, dbase, bad, t;
        do_reset();
        start_frame();
        base  = wr_addr.size();
        dbase = done_cnt;
        for (int p = 0; p < 255; p++) send_byte(8'hFF);
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL frame_valid_early got %b want 0", data_valid); end
        send_byte(8'hFF);
        t = 0;
        while (done_cnt == dbase && t < 40) begin cyc(1); t++; end
        n_cmp++; if (done_cnt - dbase !== 1) begin n_bad++; $display("FAIL frame_done_pulses got %0d want 1", done_cnt - dbase); end
        n_cmp++; if (wr_addr.size() - base !== 256) begin n_bad++; $display("FAIL frame_write_count got %0d want 256", wr_addr.size() - base); end
        bad = 0;
        for (int i = 0; i < 256 && base + i < wr_addr.size(); i++)
            if (wr_addr[base+i] !== 8'(i) || wr_data[base+i] !== 8'hFF) bad++;
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL frame_contents got %0d bad entries want 0", bad); end
        n_cmp++; if (data_valid !== 1'b1) begin n_bad++; $display("FAIL frame_valid got %b want 1", data_valid); end
        n_cmp++; if (load_checksum !== 8'h00) begin n_bad++; $display("FAIL frame_csum got %h want 00", load_checksum); end
        cyc(2);
        n_cmp++; if (MCU_RX_RDY !== 1'b1) begin n_bad++; $display("FAIL frame_rx_rdy got %b want 1", MCU_RX_RDY); end
        n_cmp++; if (data_valid !== 1'b1) begin n_bad++; $display("FAIL frame_valid_hold got %b want 1", data_valid); end
    endtask

    // Start pulse mid-frame is ignored: writes carry on at address 10.
    task automatic test_tx_rdy_midframe();
        int base;
        do_reset();
        start_frame();
        base = wr_addr.size();
        for (int p = 0; p < 10; p++) send_byte(8'(p + 8'h40));
        MCU_TX_RDY = 1'b1;
        cyc(1);
        MCU_TX_RDY = 1'b0;
        cyc(2);
        send_byte(8'h77);
        cyc(4);
        n_cmp++; if (wr_addr.size() - base !== 11) begin n_bad++; $display("FAIL midstart_count got %0d want 11", wr_addr.size() - base); end
        if (wr_addr.size() - base == 11) begin
            n_cmp++; if (wr_addr[base+10] !== 8'd10) begin n_bad++; $display("FAIL midstart_addr got %0d want 10", wr_addr[base+10]); end
            n_cmp++; if (wr_data[base+10] !== 8'h77) begin n_bad++; $display("FAIL midstart_data got %h want 77", wr_data[base+10]); end
            n_cmp++; if (wr_data[base+9] !== 8'h49) begin n_bad++; $display("FAIL midstart_prev_data got %h want 49", wr_data[base+9]); end
        end
    endtask

    // Reset at pixel 100 abandons the frame; a new start writes from 0.
    task automatic test_reset_midframe();
        int base;
        do_reset();
        start_frame();
        for (int p = 0; p < 100; p++) send_byte(8'h11);
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
        n_cmp++; if (MCU_RX_RDY !== 1'b1) begin n_bad++; $display("FAIL rstmid_rx_rdy got %b want 1", MCU_RX_RDY); end
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %b want 0", data_valid); end
        base = wr_addr.size();
        SPI_CS = 1'b0;
        send_byte(8'hEE);
        cyc(4);
        n_cmp++; if (wr_addr.size() - base !== 0) begin n_bad++; $display("FAIL rstmid_idle_writes got %0d want 0", wr_addr.size() - base); end
        start_frame();
        send_byte(8'h5A);
        cyc(4);
        n_cmp++; if (wr_addr.size() - base !== 1) begin n_bad++; $display("FAIL rstmid_restart_count got %0d want 1", wr_addr.size() - base); end
        if (wr_addr.size() - base == 1) begin
            n_cmp++; if (wr_addr[base] !== 8'h00) begin n_bad++; $display("FAIL rstmid_restart_addr got %h want 00", wr_addr[base]); end
            n_cmp++; if (wr_data[base] !== 8'h5A) begin n_bad++; $display("FAIL rstmid_restart_data got %h want 5a", wr_data[base]); end
        end
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid_after got %b want 0", data_valid); end
    endtask

    initial begin
        test_reset();
        test_byte_latency();
        test_cs_abort();
        test_full_frame();
        test_tx_rdy_midframe();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
